// File: rtl/id_ex_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_hazard_stage
// Brief    : ID/EX pipeline register. Applies the hazard unit's forwarding,
//            stall and flush decisions, and counts stall and flush events.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_hazard_stage #(
    parameter int CTRL_W     = 16,
    parameter int CNT_W      = 16,
    parameter bit FORWARD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [31:0]       id_r1_data,
    input  logic [31:0]       id_r2_data,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [4:0]        id_write_reg,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic [1:0]        forward1,
    input  logic [1:0]        forward2,
    input  logic              load_use,
    input  logic              conflict,
    input  logic [31:0]       ex_alu_result,
    input  logic [31:0]       mem_alu_result,
    input  logic [31:0]       mem_load_data,
    input  logic              flush,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ex_valid,
    output logic [31:0]       ex_op1,
    output logic [31:0]       ex_op2,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [4:0]        ex_write_reg,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [1:0]       c_fwd_reg = 2'b00;
    localparam logic [1:0]       c_fwd_mem = 2'b01;
    localparam logic [1:0]       c_fwd_ld  = 2'b10;

    logic              w_stall_req;
    logic              w_stall;
    logic              w_bubble;
    logic [31:0]       w_op1;
    logic [31:0]       w_op2;

    logic              r_ex_valid;
    logic [31:0]       r_ex_op1;
    logic [31:0]       r_ex_op2;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [4:0]        r_ex_write_reg;
    logic              r_ex_reg_write;
    logic              r_ex_mem_to_reg;
    logic [CNT_W-1:0]  r_stall_count;
    logic [CNT_W-1:0]  r_flush_count;

    // Without forwarding every RAW hazard must wait for writeback.
    assign w_stall_req = id_valid & (FORWARD_EN ? load_use : conflict);
    assign w_stall     = w_stall_req & ~flush;
    assign w_bubble    = flush | w_stall_req;

    assign pc_stall    = w_stall;
    assign ifid_stall  = w_stall;

    always_comb begin
        w_op1 = id_r1_data;
        w_op2 = id_r2_data;
        if (FORWARD_EN) begin
            case (forward1)
                c_fwd_reg: w_op1 = id_r1_data;
                c_fwd_mem: w_op1 = mem_alu_result;
                c_fwd_ld:  w_op1 = mem_load_data;
                default:   w_op1 = ex_alu_result;
            endcase
            case (forward2)
                c_fwd_reg: w_op2 = id_r2_data;
                c_fwd_mem: w_op2 = mem_alu_result;
                c_fwd_ld:  w_op2 = mem_load_data;
                default:   w_op2 = ex_alu_result;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_valid      <= 1'b0;
            r_ex_op1        <= '0;
            r_ex_op2        <= '0;
            r_ex_ctrl       <= '0;
            r_ex_write_reg  <= '0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_to_reg <= 1'b0;
        end else if (w_bubble) begin
            // Operands are left stale; a bubble never consumes them.
            r_ex_valid      <= 1'b0;
            r_ex_ctrl       <= '0;
            r_ex_write_reg  <= '0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_to_reg <= 1'b0;
        end else begin
            r_ex_valid      <= id_valid;
            r_ex_op1        <= w_op1;
            r_ex_op2        <= w_op2;
            r_ex_ctrl       <= id_ctrl;
            r_ex_write_reg  <= id_write_reg;
            r_ex_reg_write  <= id_reg_write & id_valid;
            r_ex_mem_to_reg <= id_mem_to_reg & id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_stall && (r_stall_count != c_cnt_max))
                r_stall_count <= r_stall_count + 1'b1;
            if (flush && id_valid && (r_flush_count != c_cnt_max))
                r_flush_count <= r_flush_count + 1'b1;
        end
    end

    assign ex_valid      = r_ex_valid;
    assign ex_op1        = r_ex_op1;
    assign ex_op2        = r_ex_op2;
    assign ex_ctrl       = r_ex_ctrl;
    assign ex_write_reg  = r_ex_write_reg;
    assign ex_reg_write  = r_ex_reg_write;
    assign ex_mem_to_reg = r_ex_mem_to_reg;
    assign stall_count   = r_stall_count;
    assign flush_count   = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_hazard_stage
// Brief    : Directed vectors for id_ex_hazard_stage in default, no-forward
//            and 4-bit-counter configurations sharing one stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_hazard_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_r1_data, id_r2_data;
    logic [15:0] id_ctrl;
    logic [4:0]  id_write_reg;
    logic        id_reg_write, id_mem_to_reg;
    logic [1:0]  forward1, forward2;
    logic        load_use, conflict, flush;
    logic [31:0] ex_alu_result  = 32'h44;
    logic [31:0] mem_alu_result = 32'h22;
    logic [31:0] mem_load_data  = 32'h33;

    logic        d_pcs, d_ifs, d_val, d_rw, d_m2r;
    logic [31:0] d_op1, d_op2;
    logic [15:0] d_ctrl, d_scnt, d_fcnt;
    logic [4:0]  d_wr;

    logic        n_pcs, n_ifs, n_val, n_rw, n_m2r;
    logic [31:0] n_op1, n_op2;
    logic [15:0] n_ctrl, n_scnt, n_fcnt;
    logic [4:0]  n_wr;

    logic        s_pcs, s_ifs, s_val, s_rw, s_m2r;
    logic [31:0] s_op1, s_op2;
    logic [15:0] s_ctrl;
    logic [3:0]  s_scnt, s_fcnt;
    logic [4:0]  s_wr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_ex_hazard_stage u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_r1_data(id_r1_data),
        .id_r2_data(id_r2_data), .id_ctrl(id_ctrl), .id_write_reg(id_write_reg),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .forward1(forward1),
        .forward2(forward2), .load_use(load_use), .conflict(conflict),
        .ex_alu_result(ex_alu_result), .mem_alu_result(mem_alu_result),
        .mem_load_data(mem_load_data), .flush(flush), .pc_stall(d_pcs), .ifid_stall(d_ifs),
        .ex_valid(d_val), .ex_op1(d_op1), .ex_op2(d_op2), .ex_ctrl(d_ctrl),
        .ex_write_reg(d_wr), .ex_reg_write(d_rw), .ex_mem_to_reg(d_m2r),
        .stall_count(d_scnt), .flush_count(d_fcnt));

    id_ex_hazard_stage #(.FORWARD_EN(1'b0)) u_nf (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_r1_data(id_r1_data),
        .id_r2_data(id_r2_data), .id_ctrl(id_ctrl), .id_write_reg(id_write_reg),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .forward1(forward1),
        .forward2(forward2), .load_use(load_use), .conflict(conflict),
        .ex_alu_result(ex_alu_result), .mem_alu_result(mem_alu_result),
        .mem_load_data(mem_load_data), .flush(flush), .pc_stall(n_pcs), .ifid_stall(n_ifs),
        .ex_valid(n_val), .ex_op1(n_op1), .ex_op2(n_op2), .ex_ctrl(n_ctrl),
        .ex_write_reg(n_wr), .ex_reg_write(n_rw), .ex_mem_to_reg(n_m2r),
        .stall_count(n_scnt), .flush_count(n_fcnt));

    id_ex_hazard_stage #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_r1_data(id_r1_data),
        .id_r2_data(id_r2_data), .id_ctrl(id_ctrl), .id_write_reg(id_write_reg),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .forward1(forward1),
        .forward2(forward2), .load_use(load_use), .conflict(conflict),
        .ex_alu_result(ex_alu_result), .mem_alu_result(mem_alu_result),
        .mem_load_data(mem_load_data), .flush(flush), .pc_stall(s_pcs), .ifid_stall(s_ifs),
        .ex_valid(s_val), .ex_op1(s_op1), .ex_op2(s_op2), .ex_ctrl(s_ctrl),
        .ex_write_reg(s_wr), .ex_reg_write(s_rw), .ex_mem_to_reg(s_m2r),
        .stall_count(s_scnt), .flush_count(s_fcnt));

    typedef struct {
        logic        valid;
        logic [31:0] r1, r2;
        logic [15:0] ctrl;
        logic [4:0]  wr;
        logic        rw, m2r;
        logic [1:0]  f1, f2;
        logic        lu, cf, fl;
        logic        e_stall, e_valid;
        logic [31:0] e_op1, e_op2;
        logic [15:0] e_ctrl;
        logic [4:0]  e_wr;
        logic        e_rw, e_m2r;
        logic [15:0] e_scnt, e_fcnt;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [15:0] c, input logic [4:0] w, input logic rw,
                         input logic m2r, input logic [1:0] f1, input logic [1:0] f2,
                         input logic lu, input logic cf, input logic fl);
        id_valid = v; id_r1_data = r1; id_r2_data = r2; id_ctrl = c;
        id_write_reg = w; id_reg_write = rw; id_mem_to_reg = m2r;
        forward1 = f1; forward2 = f2; load_use = lu; conflict = cf; flush = fl;
    endtask

    initial begin
        //          v  r1      r2      ctrl      wr rw m2r f1 f2 lu cf fl | stl val op1     op2     ctrl      wr rw m2r scnt fcnt
        vecs[0] = '{1, 32'h11, 32'h55, 16'h0101, 3, 1, 0, 0, 0, 0, 0, 0,  0, 1, 32'h11, 32'h55, 16'h0101, 3, 1, 0, 0, 0};
        vecs[1] = '{1, 32'h11, 32'h55, 16'h0101, 3, 1, 0, 1, 1, 0, 0, 0,  0, 1, 32'h22, 32'h22, 16'h0101, 3, 1, 0, 0, 0};
        vecs[2] = '{1, 32'h11, 32'h55, 16'h0101, 3, 1, 0, 2, 2, 0, 0, 0,  0, 1, 32'h33, 32'h33, 16'h0101, 3, 1, 0, 0, 0};
        vecs[3] = '{1, 32'h11, 32'h55, 16'h0101, 3, 1, 0, 3, 3, 0, 0, 0,  0, 1, 32'h44, 32'h44, 16'h0101, 3, 1, 0, 0, 0};
        vecs[4] = '{0, 32'h44, 32'h44, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 32'h44, 32'h44, 16'h0000, 0, 0, 0, 0, 0};
        vecs[5] = '{1, 32'h99, 32'h88, 16'h0303, 5, 1, 1, 0, 0, 1, 1, 0,  1, 0, 32'h44, 32'h44, 16'h0000, 0, 0, 0, 1, 0};
        vecs[6] = '{1, 32'h99, 32'h88, 16'h0404, 7, 1, 1, 2, 0, 0, 0, 0,  0, 1, 32'h33, 32'h88, 16'h0404, 7, 1, 1, 1, 0};
        vecs[7] = '{1, 32'h99, 32'h88, 16'h0505, 8, 1, 0, 0, 0, 1, 1, 1,  0, 0, 32'h33, 32'h88, 16'h0000, 0, 0, 0, 1, 1};
        vecs[8] = '{1, 32'h99, 32'h88, 16'h0606, 9, 1, 0, 3, 0, 0, 1, 0,  0, 1, 32'h44, 32'h88, 16'h0606, 9, 1, 0, 1, 1};
        vecs[9] = '{0, 32'hAA, 32'hBB, 16'h0707, 1, 1, 0, 0, 0, 0, 0, 1,  0, 0, 32'h44, 32'h88, 16'h0000, 0, 0, 0, 1, 1};

        // Reset with random inputs on the buses.
        rst_n = 1'b0;
        drive(1'($urandom), $urandom, $urandom, 16'($urandom), 5'($urandom), 1'($urandom),
              1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", 32'(d_val), 0);
        chk("rst_ex_op1", d_op1, 0);
        chk("rst_ex_op2", d_op2, 0);
        chk("rst_ex_ctrl", 32'(d_ctrl), 0);
        chk("rst_ex_write_reg", 32'(d_wr), 0);
        chk("rst_ex_reg_write", 32'(d_rw), 0);
        chk("rst_ex_mem_to_reg", 32'(d_m2r), 0);
        chk("rst_stall_count", 32'(d_scnt), 0);
        chk("rst_flush_count", 32'(d_fcnt), 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].r1, vecs[i].r2, vecs[i].ctrl, vecs[i].wr, vecs[i].rw,
                  vecs[i].m2r, vecs[i].f1, vecs[i].f2, vecs[i].lu, vecs[i].cf, vecs[i].fl);
            #2;
            chk($sformatf("v%0d_pc_stall", i), 32'(d_pcs), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_ifid_stall", i), 32'(d_ifs), 32'(vecs[i].e_stall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ex_valid", i), 32'(d_val), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_ex_op1", i), d_op1, vecs[i].e_op1);
            chk($sformatf("v%0d_ex_op2", i), d_op2, vecs[i].e_op2);
            chk($sformatf("v%0d_ex_ctrl", i), 32'(d_ctrl), 32'(vecs[i].e_ctrl));
            chk($sformatf("v%0d_ex_write_reg", i), 32'(d_wr), 32'(vecs[i].e_wr));
            chk($sformatf("v%0d_ex_reg_write", i), 32'(d_rw), 32'(vecs[i].e_rw));
            chk($sformatf("v%0d_ex_mem_to_reg", i), 32'(d_m2r), 32'(vecs[i].e_m2r));
            chk($sformatf("v%0d_stall_count", i), 32'(d_scnt), 32'(vecs[i].e_scnt));
            chk($sformatf("v%0d_flush_count", i), 32'(d_fcnt), 32'(vecs[i].e_fcnt));
        end

        // No-forward instance: conflict stalls for 3 cycles, forward code ignored.
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h5A, 32'h6B, 16'h0808, 4, 1, 0, 3, 3, 0, 1, 0);
            #2;
            chk($sformatf("nf_c%0d_pc_stall", i), 32'(n_pcs), 1);
            chk($sformatf("nf_c%0d_ifid_stall", i), 32'(n_ifs), 1);
            @(posedge clk);
            #1;
            chk($sformatf("nf_c%0d_ex_valid", i), 32'(n_val), 0);
        end
        drive(1, 32'h5A, 32'h6B, 16'h0808, 4, 1, 0, 3, 3, 0, 0, 0);
        #2;
        chk("nf_release_pc_stall", 32'(n_pcs), 0);
        @(posedge clk);
        #1;
        chk("nf_release_ex_valid", 32'(n_val), 1);
        chk("nf_release_ex_op1", n_op1, 32'h5A);
        chk("nf_release_ex_op2", n_op2, 32'h6B);
        chk("nf_stall_count", 32'(n_scnt), 3);

        // 4-bit counter instance: saturation at 15, then mid-stall reset.
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            drive(1, 32'h1, 32'h2, 16'h0001, 2, 1, 1, 0, 0, 1, 1, 0);
            @(posedge clk);
            #1;
            if (i == 14 || i == 15 || i == 20)
                chk($sformatf("sat_stall_count_%0d", i), 32'(s_scnt), (i < 15) ? i : 15);
        end
        rst_n = 1'b0;
        #2;
        chk("sat_rst_pc_stall_follows", 32'(s_pcs), 1);
        @(posedge clk);
        #1;
        chk("sat_rst_stall_count", 32'(s_scnt), 0);
        chk("sat_rst_ex_valid", 32'(s_val), 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
